// File: rtl/fe_fifo_unpacker_pkg.sv
// Shared definitions for the front-end FIFO unpacker: command codes (shared
// with the capture-side writer), FIFO entry field positions, FSM state and
// byte-index encodings.
package fe_fifo_unpacker_pkg;

  // Command codes carried in the top two bits of every FIFO entry
  localparam logic [1:0] FE_FIFO_CMD_DATA = 2'd0;
  localparam logic [1:0] FE_FIFO_CMD_TIME = 2'd1;
  localparam logic [1:0] FE_FIFO_CMD_STAT = 2'd2;
  localparam logic [1:0] FE_FIFO_CMD_STRM = 2'd3;

  // Entry layout: {cmd[25:24], time[23:8], data[7:0]}
  localparam int FE_CMD_MSB  = 25;
  localparam int FE_CMD_LSB  = 24;
  localparam int FE_TIME_MSB = 23;
  localparam int FE_TIME_LSB = 8;
  localparam int FE_DATA_MSB = 7;
  localparam int FE_DATA_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_HDR   = 3'd2,
    ST_B1    = 3'd3,
    ST_B2    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    IDX_HDR = 2'd0,
    IDX_B1  = 2'd1,
    IDX_B2  = 2'd2
  } byte_idx_t;

  // True when the byte presented in state st is the final byte of an entry
  // carrying command cmd.
  function automatic logic is_last_byte(input logic [1:0] cmd, input state_t st);
    logic last;
    case (st)
      ST_HDR:  last = (cmd == FE_FIFO_CMD_STRM);
      ST_B1:   last = (cmd != FE_FIFO_CMD_TIME);
      ST_B2:   last = 1'b1;
      default: last = 1'b0;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/fe_fifo_unpacker_if.sv
// FIFO read-port and byte-stream handshake bundle for the unpacker.
// slave is the unpacker side, master is the FIFO/consumer side.
interface fe_fifo_unpacker_if #(
  parameter int pFIFO_WIDTH = 26
);
  logic [pFIFO_WIDTH-1:0] I_fifo_dout;
  logic                   I_fifo_empty;
  logic                   O_fifo_rd;
  logic [7:0]             O_byte;
  logic                   O_byte_valid;
  logic                   I_byte_ready;

  modport slave (
    input  I_fifo_dout, I_fifo_empty, I_byte_ready,
    output O_fifo_rd, O_byte, O_byte_valid
  );

  modport master (
    output I_fifo_dout, I_fifo_empty, I_byte_ready,
    input  O_fifo_rd, O_byte, O_byte_valid
  );
endinterface

// File: rtl/fe_fifo_unpacker_byte_mux.sv
// fe_byte_mux: picks the header, time or data byte of a FIFO entry for a
// given byte index. Purely combinational.
module fe_byte_mux
  import fe_fifo_unpacker_pkg::*;
#(
  parameter int pTIMESTAMP_FULL_WIDTH  = 16,
  parameter int pTIMESTAMP_SHORT_WIDTH = 3,
  parameter int pDATA_WIDTH            = 8,
  parameter int pFIFO_WIDTH            = 26
) (
  input  logic [pFIFO_WIDTH-1:0] i_entry,
  input  byte_idx_t              i_idx,
  output logic [pDATA_WIDTH-1:0] o_byte
);

  logic [1:0]                        w_cmd;
  logic [pTIMESTAMP_FULL_WIDTH-1:0]  w_time;
  logic [pDATA_WIDTH-1:0]            w_data;
  logic [pTIMESTAMP_SHORT_WIDTH-1:0] w_short;

  assign w_cmd  = i_entry[FE_CMD_MSB:FE_CMD_LSB];
  assign w_time = i_entry[FE_TIME_MSB:FE_TIME_LSB];
  assign w_data = i_entry[FE_DATA_MSB:FE_DATA_LSB];

  // TIME headers carry no short timestamp; the full value follows in B1/B2
  assign w_short = (w_cmd == FE_FIFO_CMD_TIME) ? '0 : w_time[pTIMESTAMP_SHORT_WIDTH-1:0];

  // Byte selection by index: header, then time-hi or data, then time-lo
  always_comb begin
    o_byte = '0;
    case (i_idx)
      IDX_HDR: o_byte = {w_cmd, {(pDATA_WIDTH-2-pTIMESTAMP_SHORT_WIDTH){1'b0}}, w_short};
      IDX_B1:  o_byte = (w_cmd == FE_FIFO_CMD_TIME) ?
                        w_time[pTIMESTAMP_FULL_WIDTH-1 -: pDATA_WIDTH] : w_data;
      IDX_B2:  o_byte = w_time[pDATA_WIDTH-1:0];
      default: o_byte = '0;
    endcase
  end

endmodule

// File: rtl/fe_fifo_unpacker.sv
// fe_fifo_unpacker: drains the front-end capture FIFO and serialises each
// entry into 1-3 bytes on a valid/ready stream. Single clock domain.
module fe_fifo_unpacker
  import fe_fifo_unpacker_pkg::*;
#(
  parameter int pTIMESTAMP_FULL_WIDTH  = 16,
  parameter int pTIMESTAMP_SHORT_WIDTH = 3,
  parameter int pDATA_WIDTH            = 8,
  parameter int pFIFO_WIDTH            = 26
) (
  input  logic               cwusb_clk,
  input  logic               reset_i,
  input  logic               I_flush,
  output logic [31:0]        O_entry_count,
  output logic               O_busy,
  fe_fifo_unpacker_if.slave  bus
);

  state_t                 r_state;
  logic [pFIFO_WIDTH-1:0] r_entry;
  logic [7:0]             r_byte;
  logic                   r_valid;
  logic [31:0]            r_count;
  logic                   r_busy;

  logic [1:0]             w_cmd;
  logic                   w_accept;
  logic                   w_last;
  logic                   w_finish;
  logic [pFIFO_WIDTH-1:0] w_mux_entry;
  byte_idx_t              w_mux_idx;
  logic [7:0]             w_mux_byte;

  assign w_cmd    = r_entry[FE_CMD_MSB:FE_CMD_LSB];
  assign w_accept = r_valid && bus.I_byte_ready;
  assign w_last   = is_last_byte(w_cmd, r_state);
  assign w_finish = w_accept && w_last;

  // Read strobe: fetch from IDLE, or chain straight into the next entry on
  // the last accept; suppressed by flush and held low during reset
  assign bus.O_fifo_rd = reset_i && !I_flush && !bus.I_fifo_empty &&
                         ((r_state == ST_IDLE) || w_finish);

  assign bus.O_byte       = r_byte;
  assign bus.O_byte_valid = r_valid;
  assign O_entry_count    = r_count;
  assign O_busy           = r_busy;

  // Next byte to load: the header straight from the FIFO output while
  // fetching, otherwise the byte following the current one
  always_comb begin
    w_mux_entry = r_entry;
    w_mux_idx   = IDX_B2;
    case (r_state)
      ST_FETCH: begin
        w_mux_entry = bus.I_fifo_dout;
        w_mux_idx   = IDX_HDR;
      end
      ST_HDR:  w_mux_idx = IDX_B1;
      default: w_mux_idx = IDX_B2;
    endcase
  end

  fe_byte_mux #(
    .pTIMESTAMP_FULL_WIDTH  (pTIMESTAMP_FULL_WIDTH),
    .pTIMESTAMP_SHORT_WIDTH (pTIMESTAMP_SHORT_WIDTH),
    .pDATA_WIDTH            (pDATA_WIDTH),
    .pFIFO_WIDTH            (pFIFO_WIDTH)
  ) u_byte_mux (
    .i_entry (w_mux_entry),
    .i_idx   (w_mux_idx),
    .o_byte  (w_mux_byte)
  );

  // Unpacker FSM with registered byte/valid/count/busy; flush overrides all
  always_ff @(posedge cwusb_clk or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= ST_IDLE;
      r_entry <= '0;
      r_byte  <= '0;
      r_valid <= 1'b0;
      r_count <= '0;
      r_busy  <= 1'b0;
    end else if (I_flush) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_count <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!bus.I_fifo_empty) begin
            r_state <= ST_FETCH;
            r_busy  <= 1'b1;
          end
        end
        ST_FETCH: begin
          r_entry <= bus.I_fifo_dout;
          r_byte  <= w_mux_byte;
          r_valid <= 1'b1;
          r_state <= ST_HDR;
        end
        ST_HDR, ST_B1, ST_B2: begin
          if (w_accept) begin
            if (w_last) begin
              r_valid <= 1'b0;
              if (r_count != 32'hFFFF_FFFF) begin
                r_count <= r_count + 32'd1;
              end
              if (!bus.I_fifo_empty) begin
                r_state <= ST_FETCH;
              end else begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_byte  <= w_mux_byte;
              r_state <= (r_state == ST_HDR) ? ST_B1 : ST_B2;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fe_fifo_unpacker.sv
// Testbench for fe_fifo_unpacker: FIFO model feeding the DUT, a scoreboard of
// expected bytes built from the entry encoding rules, and a monitor that
// checks every accepted byte, the entry count and handshake stability.
module tb_fe_fifo_unpacker;
  import fe_fifo_unpacker_pkg::*;

  typedef struct {
    logic [7:0] value;
    bit         last;
  } expByte_t;

  logic        clk;
  logic        resetN;
  logic        flush;
  logic [31:0] entryCount;
  logic        busy;

  fe_fifo_unpacker_if bus();

  fe_fifo_unpacker dut (
    .cwusb_clk     (clk),
    .reset_i       (resetN),
    .I_flush       (flush),
    .O_entry_count (entryCount),
    .O_busy        (busy),
    .bus           (bus)
  );

  int          nChecks = 0;
  int          nFails = 0;
  logic [25:0] fifoQ[$];
  expByte_t    expQ[$];
  int          rdCount = 0;
  int          cycleNum = 0;
  int          rdCycles[$];
  int          lastAccCycles[$];
  logic [31:0] modelCount = 0;
  int          latCnt = 0;
  bit          prevStall = 0;
  bit          prevRd = 0;
  logic [7:0]  prevByte = 0;
  int          snap;

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic void pushExp(input int v, input bit last);
    expByte_t e;
    e.value = v[7:0];
    e.last  = last;
    expQ.push_back(e);
  endfunction

  // Reference encoding: derived from the command rules with plain arithmetic
  function automatic void modelBytes(input logic [25:0] entry);
    int cmd, ts, data, header;
    cmd    = int'(entry[25:24]);
    ts     = int'(entry[23:8]);
    data   = int'(entry[7:0]);
    header = cmd * 64 + ((cmd == 1) ? 0 : ts % 8);
    case (cmd)
      1: begin
        pushExp(header, 1'b0);
        pushExp(ts / 256, 1'b0);
        pushExp(ts % 256, 1'b1);
      end
      3: pushExp(header, 1'b1);
      default: begin
        pushExp(header, 1'b0);
        pushExp(data, 1'b1);
      end
    endcase
  endfunction

  task automatic applyStimulus(input logic [1:0] cmd, input logic [15:0] ts,
                               input logic [7:0] data);
    fifoQ.push_back({cmd, ts, data});
  endtask

  // FIFO model: pops on a read strobe and presents the entry the next cycle
  initial begin : fifoModel
    logic [25:0] entry;
    bit popNow;
    bus.I_fifo_empty = 1'b1;
    bus.I_fifo_dout  = '0;
    entry = '0;
    forever begin
      @(negedge clk);
      popNow = resetN && bus.O_fifo_rd;
      if (popNow) begin
        if (fifoQ.size() == 0) begin
          nChecks++;
          nFails++;
          $display("[TB] FAIL fifo_read_when_empty: read strobe with 0 entries, required none");
          popNow = 1'b0;
        end else begin
          entry = fifoQ.pop_front();
          modelBytes(entry);
        end
      end
      @(posedge clk);
      #1;
      if (popNow) bus.I_fifo_dout = entry;
      bus.I_fifo_empty = (fifoQ.size() == 0);
    end
  end

  // Monitor: scoreboard compare on accept, count tracking, stability, latency
  always @(negedge clk) begin : monitor
    expByte_t e;
    cycleNum++;
    if (!resetN) begin
      expQ.delete();
      modelCount = 0;
      latCnt     = 0;
      prevStall  = 0;
      prevRd     = 0;
    end else begin
      checkOutput("entry_count", entryCount, modelCount);
      if (prevStall) begin
        checkOutput("stall_valid_held", 32'(bus.O_byte_valid), 32'd1);
        checkOutput("stall_byte_held", 32'(bus.O_byte), 32'(prevByte));
      end
      if (latCnt > 0) begin
        latCnt--;
        if (latCnt == 0) checkOutput("rd_to_valid_latency", 32'(bus.O_byte_valid), 32'd1);
      end
      if (bus.O_fifo_rd) begin
        rdCount++;
        rdCycles.push_back(cycleNum);
        if (prevRd) checkOutput("rd_single_pulse", 32'(bus.O_fifo_rd), 32'd0);
      end
      if (flush) begin
        checkOutput("no_rd_in_flush", 32'(bus.O_fifo_rd), 32'd0);
        expQ.delete();
        modelCount = 0;
        latCnt     = 0;
      end else if (bus.O_byte_valid && bus.I_byte_ready) begin
        if (expQ.size() == 0) begin
          nChecks++;
          nFails++;
          $display("[TB] FAIL out_byte: got 0x%0h, expected no byte", bus.O_byte);
        end else begin
          e = expQ.pop_front();
          checkOutput("out_byte", 32'(bus.O_byte), 32'(e.value));
          if (e.last) begin
            if (modelCount != 32'hFFFF_FFFF) modelCount++;
            lastAccCycles.push_back(cycleNum);
          end
        end
      end
      if (bus.O_fifo_rd) latCnt = 2;
      prevStall = bus.O_byte_valid && !bus.I_byte_ready && !flush;
      prevByte  = bus.O_byte;
      prevRd    = bus.O_fifo_rd;
    end
  end

  task automatic waitIdle(input string name, input int maxCycles);
    bit done;
    done = 1'b0;
    for (int i = 0; i < maxCycles && !done; i++) begin
      @(negedge clk);
      if (fifoQ.size() == 0 && expQ.size() == 0 && !busy && !bus.O_byte_valid) done = 1'b1;
    end
    if (!done) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL %s_timeout: still busy after %0d cycles, required idle", name, maxCycles);
    end
  endtask

  task automatic waitForByte(input string name, input logic [7:0] value, input int maxCycles);
    bit done;
    done = 1'b0;
    for (int i = 0; i < maxCycles && !done; i++) begin
      @(negedge clk);
      if (bus.O_byte_valid && bus.O_byte == value) done = 1'b1;
    end
    if (!done) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL %s_timeout: byte 0x%0h never presented, required within %0d cycles",
               name, value, maxCycles);
    end
  endtask

  task automatic pulseFlush();
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  // Watchdog so the bench always terminates
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by a randomized phase
  initial begin
    resetN = 1'b0;
    flush  = 1'b0;
    bus.I_byte_ready = 1'b0;
    #2;
    checkOutput("reset_fifo_rd", 32'(bus.O_fifo_rd), 32'd0);
    checkOutput("reset_byte", 32'(bus.O_byte), 32'd0);
    checkOutput("reset_valid", 32'(bus.O_byte_valid), 32'd0);
    checkOutput("reset_count", entryCount, 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    resetN = 1'b1;

    // Single DATA entry
    bus.I_byte_ready = 1'b1;
    snap = rdCount;
    applyStimulus(FE_FIFO_CMD_DATA, 16'h0005, 8'hA7);
    waitIdle("t1", 60);
    checkOutput("t1_count", entryCount, 32'd1);
    checkOutput("t1_reads", 32'(rdCount - snap), 32'd1);
    checkOutput("t1_busy_idle", 32'(busy), 32'd0);

    // Single TIME entry
    pulseFlush();
    applyStimulus(FE_FIFO_CMD_TIME, 16'h1234, 8'h5A);
    waitIdle("t2", 60);
    checkOutput("t2_count", entryCount, 32'd1);

    // Three DATA entries back to back
    pulseFlush();
    rdCycles.delete();
    lastAccCycles.delete();
    applyStimulus(FE_FIFO_CMD_DATA, 16'h0001, 8'h11);
    applyStimulus(FE_FIFO_CMD_DATA, 16'h0002, 8'h22);
    applyStimulus(FE_FIFO_CMD_DATA, 16'h0007, 8'h33);
    waitIdle("t3", 80);
    checkOutput("t3_count", entryCount, 32'd3);
    checkOutput("t3_reads", 32'(rdCycles.size()), 32'd3);
    checkOutput("t3_finishes", 32'(lastAccCycles.size()), 32'd3);
    if (rdCycles.size() >= 3 && lastAccCycles.size() >= 3) begin
      checkOutput("t3_rd2_at_finish1", 32'(rdCycles[1]), 32'(lastAccCycles[0]));
      checkOutput("t3_rd3_at_finish2", 32'(rdCycles[2]), 32'(lastAccCycles[1]));
      checkOutput("t3_total_cycles", 32'(lastAccCycles[2] - rdCycles[0]), 32'd9);
    end

    // TIME entry with the consumer stalled in B1
    @(posedge clk); #1;
    applyStimulus(FE_FIFO_CMD_TIME, 16'h1234, 8'h00);
    waitForByte("t4_hdr", 8'h40, 40);
    @(posedge clk); #1;
    bus.I_byte_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("t4_stall_valid", 32'(bus.O_byte_valid), 32'd1);
      checkOutput("t4_stall_byte", 32'(bus.O_byte), 32'h12);
    end
    @(posedge clk); #1;
    bus.I_byte_ready = 1'b1;
    waitIdle("t4", 60);
    checkOutput("t4_count", entryCount, 32'd4);

    // Flush during B1 of a DATA entry, with a second entry waiting
    @(posedge clk); #1;
    applyStimulus(FE_FIFO_CMD_DATA, 16'h0003, 8'h5C);
    applyStimulus(FE_FIFO_CMD_DATA, 16'h0006, 8'h11);
    waitForByte("t5_hdr", 8'h03, 40);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    checkOutput("t5_rd_in_flush", 32'(bus.O_fifo_rd), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    checkOutput("t5_valid_after_flush", 32'(bus.O_byte_valid), 32'd0);
    checkOutput("t5_count_after_flush", entryCount, 32'd0);
    waitIdle("t5", 60);
    checkOutput("t5_count_next_entry", entryCount, 32'd1);

    // Asynchronous reset while the header is stalled
    @(posedge clk); #1;
    snap = rdCount;
    bus.I_byte_ready = 1'b0;
    applyStimulus(FE_FIFO_CMD_DATA, 16'h0002, 8'h99);
    applyStimulus(FE_FIFO_CMD_STAT, 16'hBEEF, 8'h42);
    waitForByte("t6_hdr", 8'h02, 40);
    @(posedge clk); #3;
    resetN = 1'b0;
    #1;
    checkOutput("t6_rst_fifo_rd", 32'(bus.O_fifo_rd), 32'd0);
    checkOutput("t6_rst_byte", 32'(bus.O_byte), 32'd0);
    checkOutput("t6_rst_valid", 32'(bus.O_byte_valid), 32'd0);
    checkOutput("t6_rst_count", entryCount, 32'd0);
    checkOutput("t6_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    resetN = 1'b1;
    bus.I_byte_ready = 1'b1;
    waitIdle("t6", 60);
    checkOutput("t6_count", entryCount, 32'd1);
    checkOutput("t6_reads", 32'(rdCount - snap), 32'd2);

    // Randomized traffic with random backpressure and occasional flush
    for (int c = 0; c < 1500; c++) begin
      logic [1:0] cmd;
      @(posedge clk); #1;
      bus.I_byte_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 49) == 0);
      if (fifoQ.size() < 4 && $urandom_range(0, 2) == 0) begin
        cmd = 2'($urandom_range(0, 3));
        applyStimulus(cmd,
                      (cmd == FE_FIFO_CMD_DATA) ? 16'($urandom_range(0, 7)) : 16'($urandom_range(0, 65535)),
                      8'($urandom_range(0, 255)));
      end
    end
    @(posedge clk); #1;
    flush = 1'b0;
    bus.I_byte_ready = 1'b1;
    waitIdle("random_drain", 200);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/fe_fifo_unpacker.md
# fe_fifo_unpacker

Read-side companion to the front-end capture logic. It drains the front-end capture FIFO, whose entries carry a 2-bit command, a full timestamp and a data byte. It serialises each entry into a compact byte stream on a valid/ready interface for the USB register read path. It runs entirely in the `cwusb_clk` domain, on the FIFO's read port.

## Interface
Parameters:
- `pTIMESTAMP_FULL_WIDTH`, 16: timestamp field width; must be 16.
- `pTIMESTAMP_SHORT_WIDTH`, 3: bits of timestamp folded into a header byte.
- `pDATA_WIDTH`, 8: data field width; must be 8.
- `pFIFO_WIDTH`, 26: entry width = 2 + `pTIMESTAMP_FULL_WIDTH` + `pDATA_WIDTH`.

Ports:
- `cwusb_clk` in 1: sole clock. One clock; reset is asynchronous and active-low.
- `reset_i` in 1: asynchronous, active-low reset.
- `I_fifo_dout` in `pFIFO_WIDTH`: entry `{cmd[25:24], time[23:8], data[7:0]}`; valid one cycle after `O_fifo_rd`.
- `I_fifo_empty` in 1: FIFO empty.
- `O_fifo_rd` out 1: read strobe, single-cycle pulse.
- `I_flush` in 1: synchronous abort; drop the entry in progress.
- `O_byte` out 8: output byte.
- `O_byte_valid` out 1: `O_byte` valid.
- `I_byte_ready` in 1: consumer accepts the byte when valid && ready.
- `O_entry_count` out 32: entries fully emitted; saturates at all-ones.
- `O_busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- Entry register captures `I_fifo_dout` in FETCH; all byte outputs are muxed from it.
- Header byte is `{cmd[1:0], 3'b000, time[2:0]}`.
- Encoding per command (codes from the package):
  - CMD_DATA (0): header, then data. Time must be ≤7 (the writer guarantees this); bits above [2:0] are ignored.
  - CMD_TIME (1): header with time[2:0]=0, then time[15:8], then time[7:0].
  - CMD_STAT (2): header, then data.
  - CMD_STRM (3): header only.
- FSM states are IDLE, FETCH, HDR, B1, B2.
  - IDLE: if `!I_fifo_empty && !I_flush`, assert `O_fifo_rd` and go to FETCH.
  - FETCH: load the entry register; go to HDR.
  - HDR: valid=1. On accept, STRM finishes; TIME goes to B1 (time hi); DATA and STAT go to B1 (data).
  - B1: on accept, TIME goes to B2 (time lo); otherwise the entry finishes.
  - B2: on accept, the entry finishes.
- Finish is the accept of an entry's last byte:
  - `O_entry_count` increments, saturating.
  - If `!I_fifo_empty`, assert `O_fifo_rd` in that same cycle and go to FETCH (back-to-back).
  - Otherwise go to IDLE.
- `I_flush` has priority over everything:
  - Next state is IDLE and valid drops next cycle.
  - `O_entry_count` clears to 0.
  - No `O_fifo_rd` is issued in the flush cycle.
  - A FIFO read already issued is discarded.
- `O_byte` and `O_byte_valid` must stay stable while valid && !ready.

## Timing
- Reset values: `O_fifo_rd`=0, `O_byte`=0, `O_byte_valid`=0, `O_entry_count`=0, `O_busy`=0. State is IDLE.
- Outputs are registered.
  - `O_fifo_rd` is the only output decoded from state and inputs, and it is glitch-free.
- Latency from `O_fifo_rd` to first `O_byte_valid` is 2 cycles.
- Best-case throughput with ready held high:
  - DATA entry: 4 cycles (rd, FETCH, HDR, B1).
  - Back-to-back steady state: 3 cycles/entry for 2-byte entries.
- `I_fifo_empty` is sampled only in IDLE and at finish; the bench must not rely on reads at other times.
- Flush and accept in the same cycle: flush wins and the count stays 0.
- Count saturation: at 0xFFFFFFFF, further finishes hold the value.
- Reset mid-entry: immediate return to IDLE; a partial entry is never resumed.

## Structure
- Shared package (`defines_pw.v`) holds:
  - `FE_FIFO_CMD_DATA`/`TIME`/`STAT`/`STRM` codes, shared with the writer.
  - Entry field bit positions.
  - State encodings as localparams.
- One natural sub-module: `fe_byte_mux`, the combinational selection of header/time/data byte from the entry register and byte index. Everything else lives in the top-level.

## Test plan
- FIFO holds one DATA entry {0, 0x0005, 0xA7}, ready high: `O_fifo_rd` pulses once; bytes 0x05, 0xA7; count=1; returns to IDLE with empty.
- TIME entry {1, 0x1234, x}: bytes 0x40, 0x12, 0x34; count=1.
- Three DATA entries queued, ready high: second `O_fifo_rd` coincides with the accept of the first entry's last byte; 6 bytes over 9 cycles; count=3.
- Ready low for 5 cycles during B1 of a TIME entry: `O_byte`=0x12 held stable with valid=1; resumes correctly.
- `I_flush` during B1 of a DATA entry: valid=0 next cycle, count=0, no read in the flush cycle; next entry decodes cleanly.
- Async reset asserted mid-HDR: all outputs 0 immediately; after release, processing starts from a fresh FIFO read.
